ft600_mode245: RTL and testbench

//  Bridge between FPGA logic and an FTDI FT600 USB3 FIFO in 245 synchronous mode.

---
 rtl/ft600_mode245.sv | 138 +++++++++++++
 tb/tb_ft600_mode245.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ft600_mode245.sv
// rtl/ft600_mode245.sv - FT600 245-sync-mode bridge between circular RX/TX byte buffers and the chip bus.
// Define FT600_TX_EN to build the FPGA->host (TX) path; without it the bridge is receive-only.
module ft600_mode245 #(
    parameter int RX_BUFFER       = 16,
    parameter int TX_BUFFER       = 16,
    parameter int RX_BUFFER_WIDTH = $clog2(RX_BUFFER),
    parameter int TX_BUFFER_WIDTH = $clog2(TX_BUFFER)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [8*RX_BUFFER-1:0]     rx_buf,
    output logic [RX_BUFFER_WIDTH-1:0] rx_buf_written,
    input  logic [8*TX_BUFFER-1:0]     tx_buf,
    input  logic [TX_BUFFER_WIDTH-1:0] tx_buf_send,
    output logic [TX_BUFFER_WIDTH-1:0] tx_buf_sent,
    input  logic                       ft_clk,
    inout  wire  [15:0]                ft_data,
    inout  wire  [1:0]                 ft_be,
    input  logic                       ft_txe,
    input  logic                       ft_rxf,
    output logic                       ft_oe,
    output logic                       ft_rd,
    output logic                       ft_wr
);

    typedef enum logic [1:0] {IDLE, RX_OE, RX_READ, TX_WRITE} state_t;

    state_t state, state_next;

    logic [TX_BUFFER_WIDTH-1:0] tx_pending;
    logic [TX_BUFFER_WIDTH-1:0] tx_step;
    logic [TX_BUFFER_WIDTH-1:0] sent_plus1;
    logic                       tx_ready;
    logic                       tx_two;
    logic                       tx_start;
    logic                       tx_accept;
    logic                       tx_drive;
    logic [15:0]                tx_word;
    logic [1:0]                 tx_be;
    logic                       unused_inputs;

    logic [RX_BUFFER_WIDTH-1:0] rx_idx1;
    logic [RX_BUFFER_WIDTH-1:0] rx_count;
    logic                       rx_capture;

`ifdef FT600_TX_EN
    assign tx_pending    = tx_buf_send - tx_buf_sent;
    assign tx_ready      = (tx_pending != '0);
    assign tx_two        = (tx_pending > TX_BUFFER_WIDTH'(1));
    assign sent_plus1    = tx_buf_sent + TX_BUFFER_WIDTH'(1);
    assign tx_word       = {tx_buf[{sent_plus1, 3'b000} +: 8], tx_buf[{tx_buf_sent, 3'b000} +: 8]};
    assign tx_be         = tx_two ? 2'b11 : 2'b01;
    assign tx_step       = tx_two ? TX_BUFFER_WIDTH'(2) : TX_BUFFER_WIDTH'(1);
    assign tx_start      = !ft_txe && tx_ready;
    assign tx_accept     = (state == TX_WRITE) && tx_ready && !ft_txe;
    assign tx_drive      = (state == TX_WRITE);
    assign ft_wr         = !((state == TX_WRITE) && tx_ready);
    assign unused_inputs = ft_clk;
`else
    assign tx_pending    = '0;
    assign tx_ready      = 1'b0;
    assign tx_two        = 1'b0;
    assign sent_plus1    = '0;
    assign tx_word       = '0;
    assign tx_be         = '0;
    assign tx_step       = '0;
    assign tx_start      = 1'b0;
    assign tx_accept     = 1'b0;
    assign tx_drive      = 1'b0;
    assign ft_wr         = 1'b1;
    assign unused_inputs = ^{ft_clk, tx_buf, tx_buf_send, ft_txe, tx_two, sent_plus1};
`endif

    // The bus is only ever driven from TX_WRITE, which is entered from IDLE (ft_oe already high).
    assign ft_data = tx_drive ? tx_word : 16'hzzzz;
    assign ft_be   = tx_drive ? tx_be   : 2'bzz;

    assign rx_capture = (state == RX_READ) && !ft_rxf;
    assign rx_idx1    = rx_buf_written + RX_BUFFER_WIDTH'(ft_be[0]);
    assign rx_count   = RX_BUFFER_WIDTH'(ft_be[0]) + RX_BUFFER_WIDTH'(ft_be[1]);

    always_comb begin
        state_next = state;
        ft_oe      = 1'b1;
        ft_rd      = 1'b1;
        case (state)
            IDLE: begin
                if (!ft_rxf) begin
                    state_next = RX_OE;
                end else if (tx_start) begin
                    state_next = TX_WRITE;
                end
            end
            RX_OE: begin
                ft_oe      = 1'b0;
                state_next = ft_rxf ? IDLE : RX_READ;
            end
            RX_READ: begin
                ft_oe = 1'b0;
                ft_rd = 1'b0;
                if (ft_rxf) begin
                    state_next = IDLE;
                end
            end
            TX_WRITE: begin
                // The last accepted word drains the buffer when pending equals this word's size.
                if (!ft_rxf || ft_txe || !tx_ready || (tx_pending == tx_step)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rx_buf         <= '0;
            rx_buf_written <= '0;
            tx_buf_sent    <= '0;
        end else begin
            state <= state_next;
            if (rx_capture) begin
                if (ft_be[0]) begin
                    rx_buf[{rx_buf_written, 3'b000} +: 8] <= ft_data[7:0];
                end
                if (ft_be[1]) begin
                    rx_buf[{rx_idx1, 3'b000} +: 8] <= ft_data[15:8];
                end
                rx_buf_written <= rx_buf_written + rx_count;
            end
            if (tx_accept) begin
                tx_buf_sent <= tx_buf_sent + tx_step;
            end
        end
    end

endmodule

// File: tb/tb_ft600_mode245.sv
// tb/tb_ft600_mode245.sv - directed bench for ft600_mode245 (TX steps follow FT600_TX_EN).
module tb_ft600_mode245;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] rx_buf;
    logic [3:0]   rx_buf_written;
    logic [127:0] tx_buf;
    logic [3:0]   tx_buf_send;
    logic [3:0]   tx_buf_sent;
    logic         ft_txe;
    logic         ft_rxf;
    logic         ft_oe;
    logic         ft_rd;
    logic         ft_wr;
    wire  [15:0]  ft_data;
    wire  [1:0]   ft_be;
    logic         host_drive;
    logic [15:0]  host_data;
    logic [1:0]   host_be;

    int errors = 0;
    int checks = 0;

    assign ft_data = host_drive ? host_data : 16'hzzzz;
    assign ft_be   = host_drive ? host_be   : 2'bzz;

    always #5 clk = ~clk;

    ft600_mode245 dut (
        .clk            (clk),
        .rst            (rst),
        .rx_buf         (rx_buf),
        .rx_buf_written (rx_buf_written),
        .tx_buf         (tx_buf),
        .tx_buf_send    (tx_buf_send),
        .tx_buf_sent    (tx_buf_sent),
        .ft_clk         (clk),
        .ft_data        (ft_data),
        .ft_be          (ft_be),
        .ft_txe         (ft_txe),
        .ft_rxf         (ft_rxf),
        .ft_oe          (ft_oe),
        .ft_rd          (ft_rd),
        .ft_wr          (ft_wr)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rxb(input int i);
        return rx_buf[8*i +: 8];
    endfunction

    // Drive a probe value onto the bus; it only reads back intact if the DUT is not driving.
    task automatic check_released(input string tag);
        host_drive = 1'b1;
        host_data  = 16'h5A5A;
        host_be    = 2'b10;
        #1;
        check({tag, "_data"}, ft_data, 16'h5A5A);
        check({tag, "_be"}, ft_be, 2'b10);
        host_drive = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; ft_rxf = 1'b1; ft_txe = 1'b1;
        tx_buf = '0; tx_buf_send = '0;
        host_drive = 1'b0; host_data = '0; host_be = '0;

        repeat (100) step();
        check("reset_oe", ft_oe, 1'b1);
        check("reset_rd", ft_rd, 1'b1);
        check("reset_wr", ft_wr, 1'b1);
        check("reset_written", rx_buf_written, 4'd0);
        check("reset_sent", tx_buf_sent, 4'd0);
        check("reset_rxbuf", rx_buf[31:0], 32'h0);
        check_released("reset_bus");
        rst = 1'b0;
        step();

        // Two-word read followed by a be=00 word that must store nothing.
        ft_rxf = 1'b0;
        step();
        check("rxoe_oe", ft_oe, 1'b0);
        check("rxoe_rd", ft_rd, 1'b1);
        step();
        check("rxread_oe", ft_oe, 1'b0);
        check("rxread_rd", ft_rd, 1'b0);
        host_drive = 1'b1; host_be = 2'b11; host_data = 16'h0123;
        step();
        host_data = 16'h4567;
        step();
        host_data = 16'hFFFF; host_be = 2'b00;
        step();
        ft_rxf = 1'b1; host_drive = 1'b0;
        check("rx2_written", rx_buf_written, 4'd4);
        step();
        check("rx2_oe_release", ft_oe, 1'b1);
        check("rx2_rd_release", ft_rd, 1'b1);
        check("rx2_bytes", rx_buf[31:0], 32'h45670123);
        check("rx2_be00_byte4", rxb(4), 8'h00);

        // Ten-word burst from a fresh reset: 19 bytes wrap the 16-byte buffer.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        ft_rxf = 1'b0;
        step();
        step();
        host_drive = 1'b1; host_be = 2'b11;
        for (int k = 0; k < 9; k++) begin
            host_data = {8'(8'h11 + 2*k), 8'(8'h10 + 2*k)};
            step();
        end
        host_data = 16'h0055; host_be = 2'b10;
        step();
        ft_rxf = 1'b1; host_drive = 1'b0;
        step();
        check("rx3_written_wrap", rx_buf_written, 4'd3);
        check("rx3_last_byte", rxb(2), 8'h00);
        check("rx3_byte0", rxb(0), 8'h20);
        check("rx3_byte1", rxb(1), 8'h21);
        check("rx3_byte3", rxb(3), 8'h13);
        check("rx3_byte15", rxb(15), 8'h1F);

        // Reset in the middle of a read burst.
        ft_rxf = 1'b0;
        step();
        step();
        host_drive = 1'b1; host_be = 2'b11; host_data = 16'hAA55;
        rst = 1'b1;
        step();
        check("midrst_oe", ft_oe, 1'b1);
        check("midrst_rd", ft_rd, 1'b1);
        check("midrst_written", rx_buf_written, 4'd0);
        check("midrst_byte0", rxb(0), 8'h00);
        rst = 1'b0; ft_rxf = 1'b1; host_drive = 1'b0;
        step();

`ifdef FT600_TX_EN
        // Three bytes: one full word then a single-byte word.
        tx_buf[23:0] = 24'hCCBBAA;
        tx_buf_send  = 4'd3;
        ft_txe       = 1'b0;
        step();
        check("tx4_wr0", ft_wr, 1'b0);
        check("tx4_oe", ft_oe, 1'b1);
        check("tx4_word0", ft_data, 16'hBBAA);
        check("tx4_be0", ft_be, 2'b11);
        step();
        check("tx4_sent_mid", tx_buf_sent, 4'd2);
        check("tx4_word1", ft_data, 16'h00CC);
        check("tx4_be1", ft_be, 2'b01);
        check("tx4_wr1", ft_wr, 1'b0);
        step();
        check("tx4_sent_end", tx_buf_sent, 4'd3);
        check("tx4_wr_end", ft_wr, 1'b1);
        check_released("tx4_bus");

        // Chip goes full for three cycles mid-burst; the held word is re-sent.
        for (int i = 0; i < 16; i++) tx_buf[8*i +: 8] = 8'(8'h30 + i);
        tx_buf_send = 4'd9;
        step();
        check("tx5_word_a", ft_data, 16'h3433);
        check("tx5_wr_a", ft_wr, 1'b0);
        step();
        check("tx5_sent_b", tx_buf_sent, 4'd5);
        ft_txe = 1'b1;
        step();
        check("tx5_wr_released", ft_wr, 1'b1);
        check("tx5_sent_held", tx_buf_sent, 4'd5);
        step();
        step();
        check("tx5_sent_held2", tx_buf_sent, 4'd5);
        check("tx5_wr_held", ft_wr, 1'b1);
        ft_txe = 1'b0;
        step();
        check("tx5_resend_word", ft_data, 16'h3635);
        check("tx5_resend_be", ft_be, 2'b11);
        check("tx5_resend_wr", ft_wr, 1'b0);
        step();
        check("tx5_sent_g", tx_buf_sent, 4'd7);
        step();
        check("tx5_sent_end", tx_buf_sent, 4'd9);
        check("tx5_wr_end", ft_wr, 1'b1);

        // RX and TX both pending in IDLE: read burst first, then the write.
        tx_buf_send = 4'd11;
        ft_rxf      = 1'b0;
        step();
        check("tx6_rx_first_oe", ft_oe, 1'b0);
        check("tx6_rx_first_wr", ft_wr, 1'b1);
        step();
        host_drive = 1'b1; host_be = 2'b11; host_data = 16'hBEEF;
        check("tx6_read_wr", ft_wr, 1'b1);
        step();
        ft_rxf = 1'b1; host_drive = 1'b0;
        step();
        check("tx6_idle_oe", ft_oe, 1'b1);
        check("tx6_idle_wr", ft_wr, 1'b1);
        step();
        check("tx6_tx_wr", ft_wr, 1'b0);
        check("tx6_tx_word", ft_data, 16'h3A39);
        step();
        check("tx6_sent_end", tx_buf_sent, 4'd11);
        check("tx6_wr_end", ft_wr, 1'b1);
        check("tx6_rx_bytes", rx_buf[15:0], 16'hBEEF);
        check("tx6_rx_written", rx_buf_written, 4'd2);
`else
        // Receive-only build: pending TX data must never reach the bus.
        tx_buf[23:0] = 24'hCCBBAA;
        tx_buf_send  = 4'd3;
        ft_txe       = 1'b0;
        repeat (3) step();
        check("notx_wr", ft_wr, 1'b1);
        check("notx_sent", tx_buf_sent, 4'd0);
        check("notx_oe", ft_oe, 1'b1);
        check_released("notx_bus");
`endif

        ft_txe = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
